// File: rtl/sampswitch_ctrl_if.sv
// Sampling-switch control interface.
// The sequencer (master) receives the conversion request, continuous-mode
// enable and timing configuration, and drives the switch phases and status
// back to the analog front end and the comparator/SAR logic (slave).
//   start, cont          : conversion request / continuous mode
//   cfg_samp/nov/hold    : track, non-overlap and hold durations in clk cycles
//   sw_clk, sw_clk_bp    : main and bottom-plate switch controls (1 = closed)
//   hold_valid           : sampled value stable
//   busy, done           : sequencer active / one-cycle completion pulse
interface sampswitch_ctrl_if #(
  parameter int CNT_W = 8,
  parameter int NOV_W = 4
);
  logic             start;
  logic             cont;
  logic [CNT_W-1:0] cfg_samp;
  logic [NOV_W-1:0] cfg_nov;
  logic [CNT_W-1:0] cfg_hold;
  logic             sw_clk;
  logic             sw_clk_bp;
  logic             hold_valid;
  logic             busy;
  logic             done;

  modport master (
    input  start, cont, cfg_samp, cfg_nov, cfg_hold,
    output sw_clk, sw_clk_bp, hold_valid, busy, done
  );

  modport slave (
    output start, cont, cfg_samp, cfg_nov, cfg_hold,
    input  sw_clk, sw_clk_bp, hold_valid, busy, done
  );
endinterface

// File: rtl/sampswitch_ctrl.sv
// Sampling-switch sequencer for the ADC front end.
// Generates registered, glitch-free track/hold phases: sw_clk (main switch),
// sw_clk_bp (bottom-plate switch, opens one cycle early), a programmable
// non-overlap gap, and hold_valid for the downstream SAR logic.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active-low
//   sw    : sampswitch_ctrl_if master modport (requests/config in, phases/status out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start or cont; all outputs low
// SAMP    | tracking: sw_clk=1, sw_clk_bp=1 for max(cfg_samp,1) cycles
// BP_OPEN | bottom plate opened first: sw_clk=1, sw_clk_bp=0, 1 cycle
// NOV     | non-overlap gap, all switches open, cfg_nov cycles
// HOLD    | hold window: hold_valid=1 for max(cfg_hold,1) cycles
module sampswitch_ctrl #(
  parameter int CNT_W = 8,
  parameter int NOV_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sampswitch_ctrl_if.master  sw
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMP    = 3'd1,
    BP_OPEN = 3'd2,
    NOV     = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [NOV_W-1:0] nov_sh, nov_sh_d;
  logic [CNT_W-1:0] hold_sh, hold_sh_d;
  logic             enter_samp;
  logic [CNT_W-1:0] samp_len, hold_len;
  logic             sw_clk_d, sw_clk_bp_d, hold_valid_d, busy_d, done_d;

  // Zero durations are promoted to one cycle. samp_len is taken from the live
  // config because the SAMP count is loaded on the same edge the shadows are.
  assign samp_len = (sw.cfg_samp == '0) ? CNT_W'(1) : sw.cfg_samp;
  assign hold_len = (hold_sh == '0) ? CNT_W'(1) : hold_sh;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    nov_sh_d   = nov_sh;
    hold_sh_d  = hold_sh;
    enter_samp = 1'b0;
    done_d     = 1'b0;

    // cnt holds the number of cycles remaining after the current one, so a
    // state ends when cnt reaches 0; it never decrements past 0.
    case (state)
      IDLE: begin
        if (sw.start || sw.cont) enter_samp = 1'b1;
      end
      SAMP: begin
        if (cnt == '0) state_d = BP_OPEN;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      BP_OPEN: begin
        if (nov_sh == '0) begin
          state_d = HOLD;
          cnt_d   = hold_len - CNT_W'(1);
        end else begin
          state_d = NOV;
          cnt_d   = CNT_W'(nov_sh) - CNT_W'(1);
        end
      end
      NOV: begin
        if (cnt == '0) begin
          state_d = HOLD;
          cnt_d   = hold_len - CNT_W'(1);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if (sw.cont) begin
            enter_samp = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Every SAMP entry re-latches the configuration, so mid-sequence cfg
    // changes only apply from the next conversion.
    if (enter_samp) begin
      state_d   = SAMP;
      cnt_d     = samp_len - CNT_W'(1);
      nov_sh_d  = sw.cfg_nov;
      hold_sh_d = sw.cfg_hold;
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state and never glitch.
    sw_clk_d     = (state_d == SAMP) || (state_d == BP_OPEN);
    sw_clk_bp_d  = (state_d == SAMP);
    hold_valid_d = (state_d == HOLD);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      nov_sh        <= '0;
      hold_sh       <= '0;
      sw.sw_clk     <= 1'b0;
      sw.sw_clk_bp  <= 1'b0;
      sw.hold_valid <= 1'b0;
      sw.busy       <= 1'b0;
      sw.done       <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      nov_sh        <= nov_sh_d;
      hold_sh       <= hold_sh_d;
      sw.sw_clk     <= sw_clk_d;
      sw.sw_clk_bp  <= sw_clk_bp_d;
      sw.hold_valid <= hold_valid_d;
      sw.busy       <= busy_d;
      sw.done       <= done_d;
    end
  end

endmodule
